// File: rtl/uart_tx_line_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_line_sched
//
// Round-robin scheduler that hands one of three ASCII lines at a time to a UART
// byte feeder. The feeder is started with a one-cycle go pulse. The scheduler
// then counts the feeder's byte-valid strobes until a whole line has gone out.
// A one-cycle gap follows before the next line is started.
//
// Optional feature macro: UART_TX_SCHED_WATCHDOG_EN
//   When defined, a 16-bit idle-byte watchdog aborts a line that stalls and
//   reports it on o_err. When undefined, the port and the logic are absent.
//
// Ports
//   i_clk_40mhz       system clock; every register uses its rising edge
//   i_rstn_40mhz      asynchronous active-low reset
//   i_req[2:0]        one-cycle line requests, one bit per requester
//   i_line0..2        ASCII line per requester; the first char is the MSB byte
//   o_grant[2:0]      one-hot pulse in the cycle a requester is selected
//   o_done[2:0]       one-hot pulse on the cycle the last byte is seen
//   o_err             watchdog abort pulse (watchdog builds only)
//   o_tx_go           one-cycle start pulse to the feeder
//   o_dat_ascii_line  latched line, held until the next grant
//   i_tx_valid        feeder byte strobe, only counted while in COUNT
//   o_busy            high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_tx_line_sched #(
    parameter int parm_ascii_line_length = 35,
    parameter int parm_timeout_cycles    = 65535
) (
    input  logic                                  i_clk_40mhz,
    input  logic                                  i_rstn_40mhz,
    input  logic [2:0]                            i_req,
    input  logic [parm_ascii_line_length*8-1:0]   i_line0,
    input  logic [parm_ascii_line_length*8-1:0]   i_line1,
    input  logic [parm_ascii_line_length*8-1:0]   i_line2,
    output logic [2:0]                            o_grant,
    output logic [2:0]                            o_done,
`ifdef UART_TX_SCHED_WATCHDOG_EN
    output logic                                  o_err,
`endif
    output logic                                  o_tx_go,
    output logic [parm_ascii_line_length*8-1:0]   o_dat_ascii_line,
    input  logic                                  i_tx_valid,
    output logic                                  o_busy
);

    localparam int LW = parm_ascii_line_length * 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GO    = 2'd1,
        ST_COUNT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t          r_state;
    logic [2:0]      r_pending;
    logic [1:0]      r_last_grant;
    logic [5:0]      r_byte_cnt;
    logic            r_tx_go;
    logic            r_busy;
    logic [LW-1:0]   r_line;

    logic [LW-1:0]   w_line_reset;
    logic [LW-1:0]   w_sel_line;
    logic [1:0]      w_cand0;
    logic [1:0]      w_cand1;
    logic [1:0]      w_cand2;
    logic [1:0]      w_sel_idx;
    logic [2:0]      w_sel_onehot;
    logic [2:0]      w_cur_onehot;
    logic            w_any_pend;
    logic            w_byte_last;
    logic            w_wd_abort;
    logic            w_finish;
    logic [2:0]      w_clr;

    // Reset line: spaces, terminated by CR LF in the last two characters
    // (character 0 sits in the MSB byte, so the last characters are the LSBs).
    generate
        for (genvar gi = 0; gi < parm_ascii_line_length; gi++) begin : g_rst_line
            if (gi == 0) begin : g_lf
                assign w_line_reset[gi*8 +: 8] = 8'h0A;
            end else if (gi == 1) begin : g_cr
                assign w_line_reset[gi*8 +: 8] = 8'h0D;
            end else begin : g_sp
                assign w_line_reset[gi*8 +: 8] = 8'h20;
            end
        end
    endgenerate

    // Round-robin search order: last_grant+1, last_grant+2, last_grant (mod 3).
    always_comb begin
        w_cand0 = 2'd0;
        w_cand1 = 2'd1;
        w_cand2 = 2'd2;
        case (r_last_grant)
            2'd0: begin w_cand0 = 2'd1; w_cand1 = 2'd2; w_cand2 = 2'd0; end
            2'd1: begin w_cand0 = 2'd2; w_cand1 = 2'd0; w_cand2 = 2'd1; end
            default: begin w_cand0 = 2'd0; w_cand1 = 2'd1; w_cand2 = 2'd2; end
        endcase
    end

    always_comb begin
        w_sel_idx = w_cand2;
        if (r_pending[w_cand0]) begin
            w_sel_idx = w_cand0;
        end else if (r_pending[w_cand1]) begin
            w_sel_idx = w_cand1;
        end
    end

    always_comb begin
        w_sel_line = i_line2;
        case (w_sel_idx)
            2'd0:    w_sel_line = i_line0;
            2'd1:    w_sel_line = i_line1;
            default: w_sel_line = i_line2;
        endcase
    end

    assign w_any_pend   = |r_pending;
    assign w_sel_onehot = 3'b001 << w_sel_idx;
    assign w_cur_onehot = 3'b001 << r_last_grant;

    // Last byte of the line: this strobe brings the count to L.
    assign w_byte_last = (r_state == ST_COUNT) && i_tx_valid &&
                         (({1'b0, r_byte_cnt} + 7'd1) == 7'(parm_ascii_line_length));

`ifdef UART_TX_SCHED_WATCHDOG_EN
    logic [15:0] r_wdog;

    // Counts consecutive COUNT cycles without a byte strobe.
    always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
        if (!i_rstn_40mhz) begin
            r_wdog <= 16'd0;
        end else if (r_state == ST_COUNT) begin
            if (i_tx_valid) begin
                r_wdog <= 16'd0;
            end else begin
                r_wdog <= r_wdog + 16'd1;
            end
        end else begin
            r_wdog <= 16'd0;
        end
    end

    // Abort on the idle cycle that takes the watchdog to the limit.
    assign w_wd_abort = (r_state == ST_COUNT) && !i_tx_valid &&
                        (({1'b0, r_wdog} + 17'd1) == 17'(parm_timeout_cycles));
    assign o_err      = w_wd_abort;
`else
    assign w_wd_abort = 1'b0;

    // Timeout parameter has no effect without the watchdog.
    if (parm_timeout_cycles < 0) begin : g_timeout_unused
    end
`endif

    assign w_finish = w_byte_last | w_wd_abort;
    assign w_clr    = w_finish ? w_cur_onehot : 3'b000;

    // Event pulses are decoded in the cycle of the deciding condition, so the
    // grant leads o_tx_go by one cycle and o_done lines up with the last strobe.
    assign o_grant          = ((r_state == ST_IDLE) && w_any_pend) ? w_sel_onehot : 3'b000;
    assign o_done           = w_byte_last ? w_cur_onehot : 3'b000;
    assign o_tx_go          = r_tx_go;
    assign o_busy           = r_busy;
    assign o_dat_ascii_line = r_line;

    // Pending bits: a new request wins over a coincident clear.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pend
            always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
                if (!i_rstn_40mhz) begin
                    r_pending[gi] <= 1'b0;
                end else if (i_req[gi]) begin
                    r_pending[gi] <= 1'b1;
                end else if (w_clr[gi]) begin
                    r_pending[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
        if (!i_rstn_40mhz) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 2'd2;
            r_byte_cnt   <= 6'd0;
            r_tx_go      <= 1'b0;
            r_busy       <= 1'b0;
            r_line       <= w_line_reset;
        end else begin
            r_tx_go <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_pend) begin
                        r_state      <= ST_GO;
                        r_last_grant <= w_sel_idx;
                        r_line       <= w_sel_line;
                        r_tx_go      <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_GO: begin
                    r_state    <= ST_COUNT;
                    r_byte_cnt <= 6'd0;
                end
                ST_COUNT: begin
                    if (w_finish) begin
                        r_state <= ST_GAP;
                    end else if (i_tx_valid) begin
                        r_byte_cnt <= r_byte_cnt + 6'd1;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_line_sched.sv
module tb_uart_tx_line_sched;

    localparam int L  = 35;
    localparam int LW = L * 8;
    localparam int TO = 100;

    logic            clk;
    logic            rstn;
    logic [2:0]      i_req;
    logic [LW-1:0]   line0, line1, line2;
    logic [2:0]      o_grant;
    logic [2:0]      o_done;
`ifdef UART_TX_SCHED_WATCHDOG_EN
    logic            o_err;
`endif
    logic            o_tx_go;
    logic [LW-1:0]   o_dat;
    logic            i_tx_valid;
    logic            o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending flags and index of the last granted requester.
    bit m_pend [3];
    int m_last;

    uart_tx_line_sched #(
        .parm_ascii_line_length (L),
        .parm_timeout_cycles    (TO)
    ) dut (
        .i_clk_40mhz      (clk),
        .i_rstn_40mhz     (rstn),
        .i_req            (i_req),
        .i_line0          (line0),
        .i_line1          (line1),
        .i_line2          (line2),
        .o_grant          (o_grant),
        .o_done           (o_done),
`ifdef UART_TX_SCHED_WATCHDOG_EN
        .o_err            (o_err),
`endif
        .o_tx_go          (o_tx_go),
        .o_dat_ascii_line (o_dat),
        .i_tx_valid       (i_tx_valid),
        .o_busy           (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] reset_line();
        logic [LW-1:0] v;
        for (int k = 0; k < L; k++) begin
            logic [7:0] ch;
            if (k == L - 1)      ch = 8'h0A;
            else if (k == L - 2) ch = 8'h0D;
            else                 ch = 8'h20;
            v[(L - 1 - k) * 8 +: 8] = ch;
        end
        return v;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < L; k++) v[k*8 +: 8] = 8'($urandom_range(32, 126));
        return v;
    endfunction

    function automatic logic [LW-1:0] line_of(input int idx);
        if (idx == 0) return line0;
        if (idx == 1) return line1;
        return line2;
    endfunction

    function automatic int m_pick();
        for (int k = 1; k <= 3; k++) begin
            int idx = (m_last + k) % 3;
            if (m_pend[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit m_any();
        return m_pend[0] | m_pend[1] | m_pend[2];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_pend[k] = 1'b0;
        m_last = 2;
    endtask

    task automatic model_req(input logic [2:0] r);
        for (int k = 0; k < 3; k++) if (r[k]) m_pend[k] = 1'b1;
    endtask

    // One clock: drive inputs just after the edge, sample shortly afterwards.
    task automatic step(input logic [2:0] req, input logic valid);
        @(posedge clk);
        #1;
        i_req      = req;
        i_tx_valid = valid;
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        i_req = 3'b000;
        i_tx_valid = 1'b0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        model_reset();
    endtask

    // Serve the next line the model expects; req_at_done is pulsed on the last byte.
    task automatic serve(input logic [2:0] req_at_done);
        int exp, n, cnt, cyc;
        logic [2:0] exp_oh;
        logic [LW-1:0] exp_line;
        logic v;
        exp = m_pick();
        exp_oh = (exp < 0) ? 3'b000 : 3'(1 << exp);
        n = 0;
        while (o_grant === 3'b000 && n < 8) begin step(3'b000, 1'b0); n++; end
        n_tests++;
        if (o_grant !== exp_oh) begin
            n_fail++;
            $display("FAIL grant: got %b expected %b", o_grant, exp_oh);
        end
        n_tests++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_in_grant_cycle: got %b expected 0", o_busy);
        end
        if (exp < 0) exp = 0;
        m_last = exp;
        exp_line = line_of(exp);
        // GO cycle: a strobe here must not be counted.
        step(3'b000, 1'($urandom_range(0, 1)));
        n_tests++;
        if (o_tx_go !== 1'b1 || o_busy !== 1'b1 || o_grant !== 3'b000) begin
            n_fail++;
            $display("FAIL go_cycle: got go=%b busy=%b grant=%b expected 1 1 000", o_tx_go, o_busy, o_grant);
        end
        n_tests++;
        if (o_dat !== exp_line) begin
            n_fail++;
            $display("FAIL latched_line: got %h expected %h", o_dat, exp_line);
        end
        cnt = 0;
        cyc = 0;
        while (cnt < L && cyc < 400) begin
            v = ($urandom_range(0, 2) != 0);
            step((cnt == L - 1 && v) ? req_at_done : 3'b000, v);
            cyc++;
            if (v) cnt++;
            n_tests++;
            if (v && cnt == L) begin
                if (o_done !== exp_oh) begin
                    n_fail++;
                    $display("FAIL done_last_byte: got %b expected %b", o_done, exp_oh);
                end
            end else if (o_done !== 3'b000 || o_tx_go !== 1'b0) begin
                n_fail++;
                $display("FAIL count_phase byte %0d: got done=%b go=%b expected 000 0", cnt, o_done, o_tx_go);
            end
        end
        if (cnt < L) begin
            n_tests++;
            n_fail++;
            $display("FAIL count_budget: got %0d bytes expected %0d", cnt, L);
        end
        m_pend[exp] = 1'b0;
        model_req(req_at_done);
        step(3'b000, 1'b1);  // GAP: strobe ignored
        n_tests++;
        if (o_busy !== 1'b1 || o_tx_go !== 1'b0 || o_done !== 3'b000 || o_dat !== exp_line) begin
            n_fail++;
            $display("FAIL gap_cycle: got busy=%b go=%b done=%b expected 1 0 000 and held line", o_busy, o_tx_go, o_done);
        end
        step(3'b000, 1'b0);  // IDLE
        n_tests++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_gap: got busy=%b expected 0", o_busy);
        end
        $display("[TB] line from requester %0d served, %0d bytes", exp, cnt);
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (o_tx_go !== 1'b0 || o_grant !== 3'b000 || o_done !== 3'b000 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got go=%b grant=%b done=%b busy=%b expected all 0", o_tx_go, o_grant, o_done, o_busy);
        end
        n_tests++;
        if (o_dat !== reset_line()) begin
            n_fail++;
            $display("FAIL reset_line: got %h expected %h", o_dat, reset_line());
        end
        $display("[TB] reset state checked");
    endtask

    task automatic test_single();
        step(3'b001, 1'b0);
        model_req(3'b001);
        step(3'b000, 1'b0);
        n_tests++;
        if (o_grant !== 3'b001) begin
            n_fail++;
            $display("FAIL single_latency: got grant %b expected 001 one cycle after request", o_grant);
        end
        serve(3'b000);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        step(3'b111, 1'b0);
        model_req(3'b111);
        for (int k = 0; k < 3; k++) serve(3'b000);
    endtask

    task automatic test_round_robin();
        apply_reset();
        step(3'b001, 1'b0);
        model_req(3'b001);
        serve(3'b101);   // 0 re-requests at its own done, 2 arrives too
        serve(3'b000);   // expected 2, not 0
        serve(3'b000);
    endtask

    task automatic test_rerequest();
        apply_reset();
        step(3'b111, 1'b0);
        model_req(3'b111);
        serve(3'b000);
        serve(3'b010);   // requester 1 pulses in its own done cycle
        serve(3'b000);
        serve(3'b000);
    endtask

    task automatic test_reset_mid_line();
        int n;
        apply_reset();
        step(3'b100, 1'b0);
        n = 0;
        while (o_grant === 3'b000 && n < 8) begin step(3'b000, 1'b0); n++; end
        step(3'b000, 1'b0);                       // GO
        repeat (10) step(3'b000, 1'b1);
        @(posedge clk);
        #2;
        i_tx_valid = 1'b1;
        #1;
        rstn = 1'b0;
        #1;
        n_tests++;
        if (o_busy !== 1'b0 || o_tx_go !== 1'b0 || o_done !== 3'b000 || o_grant !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_line: got busy=%b go=%b done=%b grant=%b expected all 0", o_busy, o_tx_go, o_done, o_grant);
        end
        n_tests++;
        if (o_dat !== reset_line()) begin
            n_fail++;
            $display("FAIL reset_mid_line_data: got %h expected %h", o_dat, reset_line());
        end
        i_tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        model_reset();
        $display("[TB] reset asserted mid-line");
        step(3'b010, 1'b0);
        model_req(3'b010);
        serve(3'b000);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            logic [2:0] rq;
            rq = 3'($urandom_range(1, 7));
            line0 = rand_line();
            line1 = rand_line();
            line2 = rand_line();
            step(rq, 1'b0);
            model_req(rq);
            while (m_any()) serve(3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)));
        end
    endtask

`ifdef UART_TX_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int n, k;
        apply_reset();
        step(3'b011, 1'b0);
        model_req(3'b011);
        n = 0;
        while (o_grant === 3'b000 && n < 8) begin step(3'b000, 1'b0); n++; end
        m_last = 0;
        step(3'b000, 1'b0);                       // GO
        repeat (5) step(3'b000, 1'b1);
        k = 0;
        n = 0;
        while (k < 300) begin
            step(3'b000, 1'b0);
            k++;
            if (o_done !== 3'b000) n++;
            if (o_err === 1'b1) break;
        end
        n_tests++;
        if (k != TO) begin
            n_fail++;
            $display("FAIL watchdog_delay: got err after %0d cycles expected %0d", k, TO);
        end
        n_tests++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL watchdog_no_done: got %0d done pulses expected 0", n);
        end
        m_pend[0] = 1'b0;
        step(3'b000, 1'b0);                       // GAP
        n_tests++;
        if (o_err !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL watchdog_gap: got err=%b busy=%b expected 0 1", o_err, o_busy);
        end
        $display("[TB] watchdog abort after %0d idle cycles", k);
        serve(3'b000);
    endtask
`endif

    initial begin
        rstn       = 1'b1;
        i_req      = 3'b000;
        i_tx_valid = 1'b0;
        line0      = rand_line();
        line1      = rand_line();
        line2      = rand_line();
        model_reset();
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_rerequest();
        test_reset_mid_line();
        test_random();
`ifdef UART_TX_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_line_sched.md
UART_TX_LINE_SCHED -- requirements
Module: uart_tx_line_sched

Interface
REQ-001 SHALL have parameter parm_ascii_line_length, default 35; the number of bytes per line, 1..63.
REQ-002 SHALL have parameter parm_timeout_cycles, default 65535; the idle-byte watchdog limit, 16-bit.
REQ-003 SHALL have port i_clk_40mhz  in  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rstn_40mhz  in  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have ports i_req[2:0]  in  3  one-cycle line-transmit request pulses, one bit per requester.
REQ-006 SHALL have ports i_line0, i_line1, i_line2  in  L*8 each  ASCII line per requester; the first character is in the MSB byte.
REQ-007 SHALL have port o_grant[2:0]  out  3  one-hot pulse in the cycle a requester's line is latched.
REQ-008 SHALL have port o_done[2:0]  out  3  one-hot pulse when the granted line has been fully fed.
REQ-009 SHALL have port o_err  out  1  one-cycle watchdog-abort pulse; exists only with the macro of REQ-027.
REQ-010 SHALL have port o_tx_go  out  1  go pulse to the feeder.
REQ-011 SHALL have port o_dat_ascii_line  out  L*8  latched line to the feeder.
REQ-012 SHALL have port i_tx_valid  in  1  the feeder's byte-valid output, monitored to count bytes.
REQ-013 SHALL have port o_busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL latch each i_req bit into a pending bit; a pulse on an already-pending bit is absorbed with no queue depth.
REQ-015 SHALL run an FSM with states IDLE, GO, COUNT and GAP, all registered.
- IDLE to GO: when any pending bit is set.
- GO to COUNT: unconditionally after one cycle.
- COUNT to GAP: when the byte count reaches L, or on watchdog abort.
- GAP to IDLE: unconditionally after one cycle.
REQ-016 SHALL, on the IDLE-to-GO edge, select a requester round-robin starting at last_grant+1 mod 3.
- The selection latches that requester's line into o_dat_ascii_line.
- o_grant pulses for the selected requester in the same cycle.
REQ-017 SHALL assert o_tx_go only in GO, for exactly one cycle.
REQ-018 SHALL hold o_dat_ascii_line constant from GO until the next grant.
REQ-019 SHALL, in COUNT, increment a 6-bit byte counter on each i_tx_valid cycle.
- The counter starts at 0 on entry to COUNT.
- On the cycle with i_tx_valid where counter+1 == L, the FSM goes to GAP.
- In that same cycle, o_done pulses and the granted pending bit is cleared.
REQ-020 SHALL give set priority when a new i_req pulse for a requester coincides with that requester's pending-bit clear: the bit stays set.
REQ-021 SHALL use GAP, one cycle with o_tx_go low, so the feeder has returned to idle before the next GO.
REQ-022 SHALL ignore i_tx_valid outside COUNT.
REQ-023 SHALL give a line latency of 2 cycles from the i_req pulse to o_tx_go when the scheduler is IDLE: one cycle to pend, one cycle to GO.
REQ-024 SHALL bound back-to-back lines by grant fairness: when all three requesters are continuously pending, grants go 0,1,2,0,...

Reset
REQ-025 SHALL, while i_rstn_40mhz is low:
- set the state to IDLE;
- clear the pending bits, counter and watchdog;
- set last_grant to 2, so the first grant goes to requester 0;
- drive o_tx_go, o_grant, o_done, o_err and o_busy to 0;
- set o_dat_ascii_line to all spaces (8'h20) except the last two bytes, which are 8'h0D and 8'h0A.
REQ-026 SHALL, on reset asserted mid-line, abandon the line immediately, with no o_done and no o_err.

Configuration
REQ-027 SHALL, with the macro UART_TX_SCHED_WATCHDOG_EN defined, run a 16-bit watchdog in COUNT.
- The watchdog clears on entry to COUNT and on each i_tx_valid.
- It increments on every other COUNT cycle.
- When it reaches parm_timeout_cycles, the FSM goes to GAP, o_err pulses and the granted pending bit is cleared, with no o_done.
REQ-028 SHALL, without UART_TX_SCHED_WATCHDOG_EN, have no watchdog logic and no o_err port, and SHALL wait indefinitely in COUNT.

Verification
REQ-029 SHALL cover single request: i_req=3'b001 with L=35 and 35 i_tx_valid pulses -> o_grant=001 and o_tx_go 1 cycle later, o_done=001 on the 35th valid, then IDLE after GAP.
REQ-030 SHALL cover simultaneous requests: i_req=3'b111 in one cycle -> grants 001, 010, 100 in order, each o_done after its 35th byte.
REQ-031 SHALL cover round-robin: after grant 0, with 0 and 2 pending -> the next grant is 100, not 001.
REQ-032 SHALL cover re-request at done: i_req[1] pulsed in requester 1's o_done cycle -> requester 1 is re-granted after the other pending requesters.
REQ-033 SHALL cover reset mid-line: i_rstn_40mhz low after byte 10 -> outputs reach their reset values asynchronously, with no o_done; requests after release are served normally.
REQ-034 SHALL cover the watchdog (macro defined, parm_timeout_cycles=100): 5 valid bytes, then none -> o_err pulses 100 cycles after the 5th byte and the next pending requester is granted.
